// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared helpers for router datapath blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    // Ceiling log2 with a floor of 1, so that a counter sized from it is never
    // zero bits wide (e.g. an occupancy count for a pipeline of depth 0).
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : router_pkg
`default_nettype wire

// File: rtl/flop_delay_stage.sv
`default_nettype none
// ============================================================================
// Module      : flop_delay_stage
// Description : One valid/data register slice of the elastic delay line.
//               Accepts whenever the slice is empty or the downstream side
//               is taking the current beat, which collapses bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module flop_delay_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    input  logic             dn_ready
);

    logic             valid_d;
    logic             valid_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Ready toward the producer; flush forces it high so nobody upstream
    // stalls while the line is being cleared.
    assign up_ready = flush | ~valid_q | dn_ready;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

    // Next-state: flush empties the slice, otherwise load when ready. The
    // payload register only moves on a valid beat so bubbles do not toggle it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (up_ready) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    // Slice registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule : flop_delay_stage
`default_nettype wire

// File: rtl/flop_delay_elastic.sv
`default_nettype none
// ============================================================================
// Module      : flop_delay_elastic
// Description : DEPTH-stage elastic register pipeline with valid/ready on
//               both sides, synchronous flush and an occupancy count.
//               DEPTH = 0 collapses to a plain wire.
// Revision    : 1.0 - initial release
// ============================================================================
module flop_delay_elastic
    import router_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int CNT_W = clog2_min1(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] count
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // No storage: handshake and payload pass straight through.
            assign o_valid = i_valid;
            assign o_data  = i_data;
            assign i_ready = o_ready;
            assign count   = '0;
        end else begin : g_pipe
            // Index 0 is the input port, index k is the output of stage k.
            logic [DEPTH:0]   w_valid;
            logic [WIDTH-1:0] w_data [DEPTH+1];
            logic             w_in_fire;
            logic             w_out_fire;
            logic [CNT_W-1:0] count_d;
            logic [CNT_W-1:0] count_q;

            assign w_valid[0] = i_valid;
            assign w_data[0]  = i_data;

            for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
                // Per-stage ready nets keep the ready chain as distinct
                // scalars rather than bits of one shared vector.
                logic w_up_ready;
                logic w_dn_ready;

                if (k == DEPTH) begin : g_last
                    assign w_dn_ready = o_ready;
                end else begin : g_mid
                    assign w_dn_ready = g_stage[k+1].w_up_ready;
                end

                flop_delay_stage #(
                    .WIDTH (WIDTH)
                ) u_stage (
                    .clk      (clk),
                    .rst_n    (rst_n),
                    .flush    (flush),
                    .up_valid (w_valid[k-1]),
                    .up_data  (w_data[k-1]),
                    .up_ready (w_up_ready),
                    .dn_valid (w_valid[k]),
                    .dn_data  (w_data[k]),
                    .dn_ready (w_dn_ready)
                );
            end

            assign i_ready    = g_stage[1].w_up_ready;
            assign o_valid    = w_valid[DEPTH];
            assign o_data     = w_data[DEPTH];
            assign w_in_fire  = i_valid & i_ready;
            assign w_out_fire = o_valid & o_ready;
            assign count      = count_q;

            // Occupancy tracks accepted minus delivered beats; a beat
            // delivered in the flush cycle is gone, so flush simply zeroes it.
            always_comb begin
                count_d = count_q;
                if (flush) begin
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(w_in_fire) - CNT_W'(w_out_fire);
                end
            end

            // Occupancy register with asynchronous clear.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end
        end
    endgenerate

endmodule : flop_delay_elastic
`default_nettype wire

// File: doc/flop_delay_elastic.md
Name: flop_delay_elastic

Overview:
- Parametrised successor to the fixed flop delay line: a DEPTH-stage register pipeline with a valid/ready handshake on both sides.
- Stages collapse bubbles, so a downstream stall back-pressures the input only once every stage is full.
- Adds a synchronous flush and an occupancy count.
- Sits between router datapath blocks that need retiming or latency matching with flow control.

Parameters:
- WIDTH, 8, payload width in bits (>=1).
- DEPTH, 2, number of register stages; 0 degenerates to a wire.
- CNT_W, $clog2(DEPTH+1) (minimum 1), width of the occupancy output; derived, not overridden.

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all stages.
- i_valid  in  1  input beat valid.
- i_ready  out  1  pipeline can accept an input beat this cycle.
- i_data  in  WIDTH  input payload.
- o_valid  out  1  output beat valid (valid bit of stage DEPTH).
- o_ready  in  1  consumer accepts the output beat.
- o_data  out  WIDTH  output payload (data of stage DEPTH).
- count  out  CNT_W  number of occupied stages.

Behaviour:
- Stage state: stage k (1..DEPTH) holds v[k] and d[k]. Stage 0 is the input port: v[0]=i_valid, d[0]=i_data.
- Ready chain (combinational, bubble-collapsing):
  - r[DEPTH]=o_ready.
  - r[k-1] = !v[k] | r[k].
  - i_ready = r[0].
- Transfer rules:
  - Stage k loads when r[k-1] is high. Then v[k] <= v[k-1]; d[k] <= d[k-1], but only when v[k-1]=1.
  - Otherwise stage k holds.
  - Data registers are not written by invalid beats, so no payload toggling on bubbles.
- Fire events: in_fire = i_valid & i_ready; out_fire = o_valid & o_ready.
- Latency and throughput:
  - An accepted beat appears on o_valid exactly DEPTH cycles later when no stall occurs.
  - Throughput is 1 beat per cycle.
  - Beat order is preserved; no beat is ever duplicated or lost except by flush.
- Stall:
  - While o_ready=0 with o_valid=1, o_data and o_valid are stable.
  - Upstream stages keep filling until all are valid; then i_ready=0.
- Handshake rule: once o_valid rises, o_valid and o_data stay stable until out_fire. No dependence of o_valid on o_ready.
- Count update (registered):
  - count <= count + in_fire - out_fire.
  - On flush, count <= 0.
  - count always equals the popcount of v[1..DEPTH] and never exceeds DEPTH.
- Flush (synchronous, highest priority):
  - All v[k] <= 0 next cycle.
  - An input beat presented during flush is dropped.
  - i_ready is forced to 1 during flush, so the producer does not hang.
  - An out_fire in the flush cycle counts as delivered.
  - d[k] holds its value.
- Reset (asynchronous, rst_n=0, any time including mid-stream):
  - All v[k]=0, d[k]=0, count=0.
  - Resulting outputs: o_valid=0, o_data=0, i_ready=1.
  - In-flight beats are discarded.
  - Deassertion is synchronised externally.
- DEPTH=0:
  - o_valid=i_valid; o_data=i_data; i_ready=o_ready; count=0.
  - flush is ignored; no registers.
- Wrap-around: none; count saturates naturally at DEPTH by construction. Assertions check 0<=count<=DEPTH.
- Simultaneous in_fire and out_fire at full occupancy is legal: r[0]=1 via the chain, and count is unchanged.

Decomposition:
- Shared package router_pkg holds the helper function clog2_min1(n) used for CNT_W. No typedefs needed; payload is an opaque WIDTH vector.
- One natural sub-module: flop_delay_stage, a single valid/data register slice with ports clk, rst_n, flush, up_valid, up_data, up_ready, dn_valid, dn_data, dn_ready.
  - The top level generates DEPTH instances and the count register.
  - The top level handles the DEPTH=0 bypass via generate.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with i_valid=1 -> o_valid=0, o_data=0, count=0, i_ready=1. After release, the first beat 0xA5 appears 2 cycles later (WIDTH=8, DEPTH=2).
- Streaming: drive 16 back-to-back beats 0..15 with o_ready=1 -> o_valid rises on cycle 2 and outputs 0..15 in order, one per cycle. count stays 2 during the steady state.
- Stall/collapse: set o_ready=0 from the cycle the first beat exits (count=2), while driving beats 1..4 -> i_ready goes 0 with count=2 and o_data=0x00 held stable. Release o_ready -> 1,2,3,4 emerge with no loss or duplication.
- Flush: fill to count=2, assert flush for 1 cycle with i_valid=1, data=0x77 -> next cycle o_valid=0 and count=0. 0x77 never appears at the output.
- Reset mid-operation: pull rst_n low asynchronously mid-cycle with count=2 -> o_valid and count drop immediately. After release, a new beat 0x3C is the only beat delivered.
- Degenerate/deep configs:
  - DEPTH=0: o_data tracks i_data combinationally and i_ready=o_ready.
  - DEPTH=5 with random valid/ready (10k cycles): scoreboard shows in-order, lossless delivery, and latency = 5 when unstalled.
